// File: rtl/simon_pkg.sv
// Shared Simon game types: state codes, LFSR polynomial and press validation helper.
// Latency: n/a (types and pure functions only); backpressure: n/a.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GROW     = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic onehot_valid(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/simon_if.sv
// Game-side bundle between the button decoder, the engine and the LED/debug display.
// Latency: n/a (wiring only); backpressure: none, all signals are levels or one-cycle pulses.
interface simon_if #(
  parameter int NUM_CH = 4,
  parameter int LW     = 5
);
  logic              tick;
  logic              start;
  logic [NUM_CH-1:0] btn;
  logic [NUM_CH-1:0] led;
  logic              error_led;
  logic              win_led;
  logic [2:0]        state;
  logic [LW-1:0]     level;
  logic              busy;

  modport master (
    output tick, start, btn,
    input  led, error_led, win_led, state, level, busy
  );

  modport slave (
    input  tick, start, btn,
    output led, error_led, win_led, state, level, busy
  );
endinterface

// File: rtl/simon_seq_mem.sv
// Sequence store: one channel number per step, written during GROW, read by step index.
// Latency: write lands at the next clk edge, read is combinational; backpressure: none.
module simon_seq_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 2,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simon_engine.sv
// Simon game core: grows an LFSR sequence, plays it on the LEDs, checks presses; SIMON_TIMEOUT_EN adds an input timeout.
// Latency: a press updates state at the edge ending its cycle, outputs follow one cycle later; backpressure: none.
module simon_engine
  import simon_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          ON_TICKS      = 2,
  parameter int          OFF_TICKS     = 1,
  parameter int          TIMEOUT_TICKS = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input logic    clk,
  input logic    reset,
  simon_if.slave bus
);

  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX  = (TMAX0 > TIMEOUT_TICKS) ? TMAX0 : TIMEOUT_TICKS;
  localparam int TW    = $clog2(TMAX + 1);

  state_t            st;
  logic [LW-1:0]     level;
  logic [LW-1:0]     idx;
  logic [15:0]       lfsr;
  logic [NUM_CH-1:0] btn_q;
  logic [TW-1:0]     tcnt;
  logic [CW-1:0]     rd_ch;
  logic [CW-1:0]     wr_ch;
  logic [NUM_CH-1:0] exp_oh;
  logic [NUM_CH-1:0] led_d;
  logic              press;
  logic              correct;
  logic              last;

  assign wr_ch   = CW'(lfsr[15:8] % 8'(NUM_CH));
  assign exp_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << rd_ch;
  // Rising edge from all-released only, so a rejected chord needs a full release
  assign press   = (bus.btn != '0) && (btn_q == '0) && onehot_valid(8'(bus.btn));
  assign correct = (bus.btn == exp_oh);
  assign last    = (idx == level - LW'(1));

  simon_seq_mem #(
    .DEPTH (MAX_LEN),
    .DW    (CW),
    .AW    (LW)
  ) u_mem (
    .clk   (clk),
    .we    (st == S_GROW),
    .waddr (level),
    .wdata (wr_ch),
    .raddr (idx),
    .rdata (rd_ch)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= S_IDLE;
      level <= '0;
      idx   <= '0;
      lfsr  <= SEED;
      btn_q <= '0;
      tcnt  <= '0;
    end else begin
      lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      btn_q <= bus.btn;
      case (st)
        S_IDLE, S_WIN, S_LOSE: begin
          if (bus.start) begin
            st    <= S_GROW;
            level <= '0;
            idx   <= '0;
            tcnt  <= '0;
          end
        end
        S_GROW: begin
          if (level != LW'(MAX_LEN)) level <= level + LW'(1);
          idx  <= '0;
          tcnt <= '0;
          st   <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (bus.tick) begin
            if (tcnt == TW'(ON_TICKS - 1)) begin
              st   <= S_SHOW_OFF;
              tcnt <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        S_SHOW_OFF: begin
          if (bus.tick) begin
            if (tcnt == TW'(OFF_TICKS - 1)) begin
              tcnt <= '0;
              if (last) begin
                st  <= S_INPUT;
                idx <= '0;
              end else begin
                st  <= S_SHOW_ON;
                idx <= idx + LW'(1);
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        S_INPUT: begin
          // A press in the same cycle as a tick wins and restarts the tick count
          if (press) begin
            tcnt <= '0;
            if (!correct)                   st  <= S_LOSE;
            else if (!last)                 idx <= idx + LW'(1);
            else if (level == LW'(MAX_LEN)) st  <= S_WIN;
            else                            st  <= S_GROW;
          end
`ifdef SIMON_TIMEOUT_EN
          else if (bus.tick) begin
            if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
              st   <= S_LOSE;
              tcnt <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
`endif
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    case (st)
      S_SHOW_ON, S_LOSE: led_d = exp_oh;
      S_INPUT:           led_d = btn_q;
      S_WIN:             led_d = '1;
      default:           led_d = '0;
    endcase
  end

  assign bus.led       = led_d;
  assign bus.error_led = (st == S_LOSE);
  assign bus.win_led   = (st == S_WIN);
  assign bus.busy      = (st != S_IDLE) && (st != S_WIN) && (st != S_LOSE);
  assign bus.state     = st;
  assign bus.level     = level;

endmodule

// File: tb/tb_simon_engine.sv
// Randomized bench for simon_engine (4 channels, 2-step game) against a sequence-level model.
module tb_simon_engine;

  localparam int          NUM_CH  = 4;
  localparam int          MAX_LEN = 2;
  localparam int          LW      = $clog2(MAX_LEN + 1);
  localparam logic [15:0] SEED    = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simon_if #(.NUM_CH(NUM_CH), .LW(LW)) bus ();

  simon_engine #(
    .NUM_CH        (NUM_CH),
    .MAX_LEN       (MAX_LEN),
    .ON_TICKS      (2),
    .OFF_TICKS     (1),
    .TIMEOUT_TICKS (8),
    .SEED          (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks;
  int n_fail;
  bit tick_auto;
  int base;

  // Reference: the x^16+x^14+x^13+x^11 sequence advanced once per clock since reset,
  // sampled whenever a new step is appended to the game sequence
  logic [15:0] m_lfsr;
  int          q[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(negedge clk) begin
    if (reset && bus.state == 3'd1) q.push_back(int'(m_lfsr[15:8]) % NUM_CH);
  end

  function automatic logic [3:0] oh(input int c);
    logic [3:0] r;
    r = 4'b0001 << c;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    bus.tick = tick_auto ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic pulse_tick();
    cyc();
    bus.tick = 1'b1;
    cyc();
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (bus.state !== s && n < 400) begin
      cyc();
      n++;
    end
    check_eq(tag, bus.state, s);
  endtask

  task automatic press(input logic [3:0] v);
    cyc();
    bus.btn = v;
    cyc();
  endtask

  task automatic release_btn();
    repeat ($urandom_range(0, 2)) cyc();
    bus.btn = '0;
    cyc();
  endtask

  task automatic start_game();
    cyc();
    base = q.size();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_eq("grow_state", bus.state, 3'd1);
  endtask

  // Watch the whole playback of the current round and land in INPUT
  task automatic show_seq(output int len);
    cyc();
    len = q.size() - base;
    check_eq("round_level", bus.level, len);
    for (int i = 0; i < len; i++) begin
      wait_state(3'd2, "show_on");
      check_eq("show_led", bus.led, oh(q[base + i]));
      wait_state(3'd3, "show_off");
      check_eq("off_led", bus.led, 4'b0000);
    end
    wait_state(3'd4, "input");
  endtask

  task automatic play_round();
    int len;
    show_seq(len);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(1, 3)) cyc();
      press(oh(q[base + i]));
      if (i < len - 1) begin
        check_eq("mid_state", bus.state, 3'd4);
        check_eq("echo_led", bus.led, oh(q[base + i]));
      end else begin
        check_eq("round_end", bus.state, (len == MAX_LEN) ? 3'd5 : 3'd1);
      end
      release_btn();
    end
  endtask

  initial begin
    int len;
    int n;
    logic [3:0] wrong;
    n_checks  = 0;
    n_fail    = 0;
    tick_auto = 1'b0;
    base      = 0;
    reset     = 1'b0;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.btn   = '0;
    repeat (4) cyc();
    check_eq("rst_state_held", bus.state, 3'd0);
    reset     = 1'b1;
    tick_auto = 1'b1;
    cyc();
    check_eq("rst_state", bus.state, 3'd0);
    check_eq("rst_led", bus.led, 4'b0000);
    check_eq("rst_error", bus.error_led, 1'b0);
    check_eq("rst_win", bus.win_led, 1'b0);
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_busy", bus.busy, 1'b0);
    repeat (20) cyc();
    check_eq("idle_hold_state", bus.state, 3'd0);
    check_eq("idle_hold_led", bus.led, 4'b0000);

    // Full game to WIN
    start_game();
    check_eq("grow_busy", bus.busy, 1'b1);
    play_round();
    play_round();
    check_eq("win_led", bus.win_led, 1'b1);
    check_eq("win_leds", bus.led, 4'b1111);
    check_eq("win_level", bus.level, MAX_LEN);
    check_eq("win_busy", bus.busy, 1'b0);
    repeat (10) cyc();
    check_eq("win_hold", bus.state, 3'd5);

    // Wrong channel in round 1
    start_game();
    show_seq(len);
    wrong = oh(int'((q[base] + 1 + int'($urandom_range(0, 2))) % NUM_CH));
    press(wrong);
    check_eq("lose_state", bus.state, 3'd6);
    check_eq("lose_error", bus.error_led, 1'b1);
    check_eq("lose_led", bus.led, oh(q[base]));
    check_eq("lose_busy", bus.busy, 1'b0);
    release_btn();
    repeat (5) cyc();
    check_eq("lose_hold", bus.state, 3'd6);
    check_eq("lose_led_hold", bus.led, oh(q[base]));

    // Chord is ignored, then a clean single press advances
    start_game();
    show_seq(len);
    press(4'b0011);
    check_eq("chord_state", bus.state, 3'd4);
    check_eq("chord_echo", bus.led, 4'b0011);
    release_btn();
    press(oh(q[base]));
    check_eq("after_chord", bus.state, 3'd1);
    release_btn();

    // start ignored mid-playback, then async reset mid-game
    wait_state(3'd2, "r2_show_on");
    tick_auto = 1'b0;
    bus.tick  = 1'b0;
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_eq("start_ignored", bus.state, 3'd2);
    check_eq("start_ign_level", bus.level, 2);
    reset = 1'b0;
    #1;
    check_eq("midrst_state", bus.state, 3'd0);
    check_eq("midrst_level", bus.level, 0);
    check_eq("midrst_led", bus.led, 4'b0000);
    cyc();
    reset = 1'b1;

    // Fresh game with hand-driven ticks, then the input timeout
    start_game();
    cyc();
    check_eq("restart_level", bus.level, 1);
    check_eq("restart_show", bus.led, oh(q[base]));
    n = 0;
    while (bus.state !== 3'd4 && n < 20) begin
      pulse_tick();
      n++;
    end
    check_eq("to_input", bus.state, 3'd4);
    repeat (7) pulse_tick();
    check_eq("to_7ticks", bus.state, 3'd4);
    pulse_tick();
`ifdef SIMON_TIMEOUT_EN
    check_eq("to_8ticks", bus.state, 3'd6);
    check_eq("to_error", bus.error_led, 1'b1);
`else
    check_eq("to_8ticks", bus.state, 3'd4);
    repeat (92) pulse_tick();
    check_eq("no_timeout_100", bus.state, 3'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simon_engine.md
# simon_engine

Parametrised Simon game engine: grows a pseudo-random sequence by one step per round, plays it on `NUM_CH` LEDs, then checks the player's button entries against it, ending in WIN at `MAX_LEN` steps or LOSE on the first mistake. It is the next-generation game core: variable channel count and depth, a growing random sequence held internally, timed playback, and an optional input timeout. It sits between the button decoder/debouncer and the LED/7-seg debug display, clocked by the system clock and paced by a one-cycle `tick` enable from the clock divider.

## Interface
- `NUM_CH`, 4: buttons/LEDs, 2–8.
- `MAX_LEN`, 16: winning sequence length, 1–64.
- `ON_TICKS`, 2: ticks each step's LED is lit, ≥1.
- `OFF_TICKS`, 1: ticks of dark gap after each step, ≥1.
- `TIMEOUT_TICKS`, 8: ticks allowed between presses; only used when `SIMON_TIMEOUT_EN` is defined.
- `SEED`, 16'hACE1: LFSR reset value, nonzero.

- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low.
- `tick` in 1: one-`clk` pulse, about 4 Hz.
- `start` in 1: level; starts a new game.
- `btn` in `NUM_CH`: debounced button levels.
- `led` out `NUM_CH`: game LEDs.
- `error_led` out 1: high in LOSE.
- `win_led` out 1: high in WIN.
- `state` out 3: state encoding.
- `level` out `LW`=$clog2(`MAX_LEN`+1): current sequence length.
- `busy` out 1: high in any state except IDLE, WIN and LOSE.

## Operation
- States and codes: IDLE=0, GROW=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, WIN=5, LOSE=6.
- `start` high in IDLE, WIN or LOSE: go to GROW and clear `level` to 0. `start` is ignored in all other states.
- GROW, one cycle:
  - write `lfsr[15:8] % NUM_CH` to `mem[level]`;
  - increment `level`;
  - clear `idx`;
  - go to SHOW_ON.
- SHOW_ON: `led` = one-hot of `mem[idx]`. After `ON_TICKS` tick pulses, go to SHOW_OFF.
- SHOW_OFF: `led`=0. After `OFF_TICKS` tick pulses:
  - if `idx`==`level`-1, go to INPUT with `idx`=0;
  - otherwise increment `idx` and go to SHOW_ON.
- INPUT: `led` = `btn_q`, echoing the held button.
- Press event: `btn`!=0 and `btn_q`==0, where `btn_q` is `btn` registered every cycle.
  - A non-one-hot press is ignored and needs a full release before the next press.
  - Press events outside INPUT are ignored.
- Valid press in INPUT:
  - wrong channel: go to LOSE;
  - correct channel and `idx`<`level`-1: increment `idx`;
  - correct channel and `idx`==`level`-1: go to WIN if `level`==`MAX_LEN`, otherwise go to GROW.
- LOSE: `error_led`=1. `led` = one-hot of the expected `mem[idx]`, and `idx` is frozen. Held until `start`.
- WIN: `win_led`=1, `led` all ones. Held until `start`.
- IDLE: all LEDs 0.
- LFSR: 16-bit Galois, taps 16,14,13,11. It steps every `clk`, so the sequence depends on press timing.
- Tick counter: cleared on every state change; counts `tick` pulses only.

## Timing
- Reset values: `led`=0, `error_led`=0, `win_led`=0, `state`=IDLE, `level`=0, `busy`=0, `idx`=0, `lfsr`=`SEED`, `btn_q`=0. `mem` is not cleared.
- Every output is registered or decoded from registers only; no combinational path from `btn` or `start`.
- Press latency: a press in cycle t updates `state`/`idx` at the edge ending t. The outputs reflect it in cycle t+1.
- `tick` and a press in the same cycle: the press is processed, and the tick counter clears on any resulting state change.
- SHOW_ON ends on the `ON_TICKS`-th tick pulse seen after entry. The same rule applies to SHOW_OFF and the timeout.
- Reset asserted mid-game: returns to IDLE immediately. The stale `mem` is unreachable because `level`=0.
- `level` saturates at `MAX_LEN`. `idx` never exceeds `level`-1.

## Configuration
- `SIMON_TIMEOUT_EN` defined:
  - in INPUT, `TIMEOUT_TICKS` tick pulses with no valid press cause LOSE;
  - each valid correct press clears the counter.
- Not defined: INPUT waits indefinitely. The timeout counter and its compare are not built.

## Structure
- `simon_pkg`:
  - state enum and codes;
  - LFSR tap constant;
  - `onehot_valid` function.
- Sub-module `simon_seq_mem`:
  - `MAX_LEN` × $clog2(`NUM_CH`) register array;
  - synchronous write, combinational read;
  - no reset on the array.
- Everything else lives in `simon_engine`: FSM, LFSR, tick counter, index counter and edge detect.

## Test plan
- Reset check: hold `reset`=0, then release. Require every output at its reset value and `state`=0, with no change before `start`.
- `NUM_CH`=4, `MAX_LEN`=2:
  - pulse `start`; read the shown channel from `led` during SHOW_ON and press it;
  - require `level` 1→2, then two shown steps;
  - replay both correctly; require `state`=5, `win_led`=1, `led`=4'b1111.
- Round 1 with a wrong channel pressed: require `state`=6, `error_led`=1 and `led` = one-hot of the shown channel on cycle t+1.
- Press `btn`=4'b0011 in INPUT: ignored, `state` stays 4. After release, a correct single press advances normally.
- With `SIMON_TIMEOUT_EN` and `TIMEOUT_TICKS`=8: no press gives LOSE on the 8th tick. Without the macro, still INPUT after 100 ticks.
- Mid-game events:
  - `start` during SHOW_ON: no effect;
  - `reset` low during SHOW_ON: immediate IDLE with `level`=0, then a new game starts cleanly at `level`=1.
